// File: rtl/duck_motion.sv
// rtl/duck_motion.sv - duck sprite motion controller: spawn, fly/bounce, hit freeze, fall or escape
module duck_motion #(
  parameter int SCREEN_W   = 640,
  parameter int GROUND_Y   = 400,
  parameter int DUCK_W     = 32,
  parameter int DUCK_H     = 32,
  parameter int SPEED      = 2,
  parameter int FALL_SPEED = 4,
  parameter int HIT_TICKS  = 30,
  parameter int FLY_TICKS  = 300
) (
  input  logic       clk25m,
  input  logic       reset,
  input  logic       tick60,
  input  logic       spawn,
  input  logic [9:0] spawn_x,
  input  logic       spawn_left,
  input  logic       hit,
  output logic [9:0] duck_x,
  output logic [9:0] duck_y,
  output logic       facing_left,
  output logic [2:0] state,
  output logic       done,
  output logic       shot_down
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FLYING   = 3'd1,
    S_HIT      = 3'd2,
    S_FALLING  = 3'd3,
    S_ESCAPING = 3'd4
  } state_t;

  localparam int CW = $clog2((FLY_TICKS > HIT_TICKS ? FLY_TICKS : HIT_TICKS) + 1);

  // Position math is done 12-bit signed so stepping past either edge never wraps.
  localparam logic signed [11:0] X_MAX = 12'(SCREEN_W - DUCK_W);
  localparam logic signed [11:0] Y_MAX = 12'(GROUND_Y - DUCK_H);
  localparam logic signed [11:0] SPD   = 12'(SPEED);
  localparam logic signed [11:0] FSPD  = 12'(FALL_SPEED);
  localparam logic [9:0]         X_MAX10 = 10'(SCREEN_W - DUCK_W);
  localparam logic [9:0]         Y_MAX10 = 10'(GROUND_Y - DUCK_H);
  localparam logic [CW-1:0]      FLY_CNT = CW'(FLY_TICKS);
  localparam logic [CW-1:0]      HIT_CNT = CW'(HIT_TICKS);

  state_t          state_q, state_d;
  logic [9:0]      x_q, x_d, y_q, y_d;
  logic            left_q, left_d, up_q, up_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic            done_q, done_d, shot_q, shot_d;

  logic signed [11:0] x_s, y_s, nx, ny, y_fall, y_rise;

  always_ff @(posedge clk25m) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= Y_MAX10;
      left_q  <= 1'b0;
      up_q    <= 1'b1;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      shot_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      left_q  <= left_d;
      up_q    <= up_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      shot_q  <= shot_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    left_d  = left_q;
    up_d    = up_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    shot_d  = shot_q;
    cnt_inc = cnt_q + CW'(1);
    x_s     = $signed({2'b00, x_q});
    y_s     = $signed({2'b00, y_q});
    nx      = left_q ? (x_s - SPD) : (x_s + SPD);
    ny      = up_q ? (y_s - SPD) : (y_s + SPD);
    y_fall  = y_s + FSPD;
    y_rise  = y_s - SPD;

    case (state_q)
      S_IDLE: begin
        if (spawn) begin
          x_d     = (spawn_x > X_MAX10) ? X_MAX10 : spawn_x;
          y_d     = Y_MAX10;
          left_d  = spawn_left;
          up_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_FLYING;
        end
      end
      S_FLYING: begin
        if (hit) begin
          cnt_d   = '0;
          state_d = S_HIT;
        end else if (tick60) begin
          // Touching an edge counts as the bounce, so the duck never lingers on it.
          if (nx <= 12'sd0) begin
            x_d    = '0;
            left_d = ~left_q;
          end else if (nx >= X_MAX) begin
            x_d    = X_MAX10;
            left_d = ~left_q;
          end else begin
            x_d = nx[9:0];
          end
          if (ny <= 12'sd0) begin
            y_d  = '0;
            up_d = ~up_q;
          end else if (ny >= Y_MAX) begin
            y_d  = Y_MAX10;
            up_d = ~up_q;
          end else begin
            y_d = ny[9:0];
          end
          cnt_d = cnt_inc;
          if (cnt_inc == FLY_CNT) state_d = S_ESCAPING;
        end
      end
      S_HIT: begin
        if (tick60) begin
          if (cnt_inc == HIT_CNT) begin
            cnt_d   = '0;
            state_d = S_FALLING;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_FALLING: begin
        if (tick60) begin
          if (y_fall >= Y_MAX) begin
            y_d     = Y_MAX10;
            done_d  = 1'b1;
            shot_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            y_d = y_fall[9:0];
          end
        end
      end
      S_ESCAPING: begin
        if (tick60) begin
          if (y_s <= SPD) begin
            y_d     = '0;
            done_d  = 1'b1;
            shot_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            y_d = y_rise[9:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign duck_x      = x_q;
  assign duck_y      = y_q;
  assign facing_left = left_q;
  assign state       = state_q;
  assign done        = done_q;
  assign shot_down   = shot_q;

endmodule

// File: tb/tb_duck_motion.sv
// tb/tb_duck_motion.sv - self-checking bench for duck_motion with table vectors and a random model run
module tb_duck_motion;

  localparam int XMAX = 608;
  localparam int YMAX = 368;

  logic       clk25m = 1'b0;
  logic       reset = 1'b0;
  logic       tick60 = 1'b0;
  logic       spawn = 1'b0;
  logic [9:0] spawn_x = '0;
  logic       spawn_left = 1'b0;
  logic       hit = 1'b0;
  logic [9:0] duck_x, duck_y;
  logic       facing_left;
  logic [2:0] state;
  logic       done, shot_down;

  duck_motion dut (
    .clk25m(clk25m), .reset(reset), .tick60(tick60), .spawn(spawn),
    .spawn_x(spawn_x), .spawn_left(spawn_left), .hit(hit),
    .duck_x(duck_x), .duck_y(duck_y), .facing_left(facing_left),
    .state(state), .done(done), .shot_down(shot_down)
  );

  always #20 clk25m = ~clk25m;

  int vectors = 0;
  int miscompares = 0;

  int m_state, m_x, m_y, m_left, m_up, m_cnt, m_done, m_shot;

  typedef struct {
    int sx; int sl; int ticks;
    int ex; int ey; int ef; int est;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference behaviour expressed as whole-tick position rules.
  task automatic model_step(input bit rst, input bit sp, input bit tk, input bit ht,
                            input int sx, input int sl);
    if (rst) begin
      m_state = 0; m_x = 0; m_y = YMAX; m_left = 0; m_up = 1;
      m_cnt = 0; m_done = 0; m_shot = 0;
      return;
    end
    m_done = 0;
    case (m_state)
      0: if (sp) begin
        m_x = (sx > XMAX) ? XMAX : sx;
        m_y = YMAX; m_left = sl; m_up = 1; m_cnt = 0; m_state = 1;
      end
      1: if (ht) begin
        m_state = 2; m_cnt = 0;
      end else if (tk) begin
        m_x = m_x + (m_left ? -2 : 2);
        if (m_x <= 0) begin m_x = 0; m_left = !m_left; end
        else if (m_x >= XMAX) begin m_x = XMAX; m_left = !m_left; end
        m_y = m_y + (m_up ? -2 : 2);
        if (m_y <= 0) begin m_y = 0; m_up = !m_up; end
        else if (m_y >= YMAX) begin m_y = YMAX; m_up = !m_up; end
        m_cnt++;
        if (m_cnt == 300) m_state = 4;
      end
      2: if (tk) begin
        m_cnt++;
        if (m_cnt == 30) begin m_state = 3; m_cnt = 0; end
      end
      3: if (tk) begin
        if (m_y + 4 >= YMAX) begin m_y = YMAX; m_done = 1; m_shot = 1; m_state = 0; end
        else m_y = m_y + 4;
      end
      4: if (tk) begin
        if (m_y <= 2) begin m_y = 0; m_done = 1; m_shot = 0; m_state = 0; end
        else m_y = m_y - 2;
      end
      default: m_state = 0;
    endcase
  endtask

  task automatic cyc(input bit rst, input bit sp, input bit tk, input bit ht);
    reset = rst; spawn = sp; tick60 = tk; hit = ht;
    @(posedge clk25m);
    model_step(rst, sp, tk, ht, int'(spawn_x), int'(spawn_left));
    #1;
    reset = 1'b0; spawn = 1'b0; tick60 = 1'b0; hit = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 1, 0);
  endtask

  task automatic check_model();
    chk("rand_x", int'(duck_x), m_x);
    chk("rand_y", int'(duck_y), m_y);
    chk("rand_facing", int'(facing_left), m_left);
    chk("rand_state", int'(state), m_state);
    chk("rand_done", int'(done), m_done);
    chk("rand_shot", int'(shot_down), m_shot);
  endtask

  initial begin
    vecs[0] = '{sx: 100, sl: 0, ticks: 10,  ex: 120, ey: 348, ef: 0, est: 1};
    vecs[1] = '{sx: 606, sl: 0, ticks: 1,   ex: 608, ey: 366, ef: 1, est: 1};
    vecs[2] = '{sx: 606, sl: 0, ticks: 2,   ex: 606, ey: 364, ef: 1, est: 1};
    vecs[3] = '{sx: 0,   sl: 1, ticks: 1,   ex: 0,   ey: 366, ef: 0, est: 1};
    vecs[4] = '{sx: 700, sl: 0, ticks: 0,   ex: 608, ey: 368, ef: 0, est: 1};
    vecs[5] = '{sx: 5,   sl: 1, ticks: 3,   ex: 0,   ey: 362, ef: 0, est: 1};
    vecs[6] = '{sx: 100, sl: 0, ticks: 190, ex: 480, ey: 12,  ef: 0, est: 1};

    #5;
    cyc(1, 0, 0, 0);
    chk("reset_state", int'(state), 0);
    chk("reset_x", int'(duck_x), 0);
    chk("reset_y", int'(duck_y), 368);
    chk("reset_facing", int'(facing_left), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_shot", int'(shot_down), 0);

    foreach (vecs[i]) begin
      cyc(1, 0, 0, 0);
      spawn_x = 10'(vecs[i].sx);
      spawn_left = vecs[i].sl[0];
      cyc(0, 1, 0, 0);
      ticks(vecs[i].ticks);
      chk($sformatf("vec%0d_x", i), int'(duck_x), vecs[i].ex);
      chk($sformatf("vec%0d_y", i), int'(duck_y), vecs[i].ey);
      chk($sformatf("vec%0d_facing", i), int'(facing_left), vecs[i].ef);
      chk($sformatf("vec%0d_state", i), int'(state), vecs[i].est);
    end

    // Escape round: climb, bounce off the top, escape upward.
    cyc(1, 0, 0, 0);
    spawn_x = 10'd100; spawn_left = 1'b0;
    cyc(0, 1, 0, 0);
    ticks(300);
    chk("esc_state", int'(state), 4);
    chk("esc_y", int'(duck_y), 232);
    cyc(0, 0, 1, 1);
    chk("esc_hit_ignored", int'(state), 4);
    chk("esc_hit_y", int'(duck_y), 230);
    ticks(114);
    chk("esc_pre_y", int'(duck_y), 2);
    chk("esc_pre_done", int'(done), 0);
    ticks(1);
    chk("esc_done", int'(done), 1);
    chk("esc_shot", int'(shot_down), 0);
    chk("esc_idle", int'(state), 0);
    chk("esc_y0", int'(duck_y), 0);
    cyc(0, 0, 0, 0);
    chk("esc_done_pulse", int'(done), 0);

    // Shot-down round with hit and tick colliding.
    cyc(1, 0, 0, 0);
    spawn_x = 10'd100; spawn_left = 1'b0;
    cyc(0, 1, 0, 0);
    ticks(60);
    spawn_x = 10'd0;
    cyc(0, 1, 0, 0);
    chk("fly_spawn_ignored_x", int'(duck_x), 220);
    cyc(0, 0, 1, 1);
    chk("hit_state", int'(state), 2);
    chk("hit_x", int'(duck_x), 220);
    chk("hit_y", int'(duck_y), 248);
    ticks(29);
    cyc(0, 0, 0, 1);
    chk("hit_hold_state", int'(state), 2);
    chk("hit_hold_y", int'(duck_y), 248);
    ticks(1);
    chk("fall_state", int'(state), 3);
    ticks(29);
    cyc(0, 1, 0, 1);
    chk("fall_y", int'(duck_y), 364);
    chk("fall_ignore_state", int'(state), 3);
    chk("fall_x", int'(duck_x), 220);
    ticks(1);
    chk("fall_done", int'(done), 1);
    chk("fall_shot", int'(shot_down), 1);
    chk("fall_y_clamp", int'(duck_y), 368);
    chk("fall_idle", int'(state), 0);
    cyc(0, 0, 0, 0);
    chk("fall_done_pulse", int'(done), 0);
    chk("fall_shot_hold", int'(shot_down), 1);

    // Reset mid-fall aborts without done.
    cyc(1, 0, 0, 0);
    spawn_x = 10'd300; spawn_left = 1'b1;
    cyc(0, 1, 0, 0);
    ticks(20);
    cyc(0, 0, 0, 1);
    ticks(33);
    chk("rstfall_y", int'(duck_y), 340);
    chk("rstfall_pre_state", int'(state), 3);
    cyc(1, 0, 0, 0);
    chk("rstfall_state", int'(state), 0);
    chk("rstfall_y368", int'(duck_y), 368);
    chk("rstfall_done", int'(done), 0);
    spawn_x = 10'd50; spawn_left = 1'b0;
    cyc(0, 1, 0, 0);
    chk("rstfall_respawn_state", int'(state), 1);
    chk("rstfall_respawn_x", int'(duck_x), 50);

    // Random traffic against the model.
    cyc(1, 0, 0, 0);
    for (int n = 0; n < 20000; n++) begin
      spawn_x = 10'($urandom_range(0, 1023));
      spawn_left = 1'($urandom_range(0, 1));
      cyc($urandom_range(0, 2999) == 0, $urandom_range(0, 19) == 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 299) == 0);
      check_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
